// File: rtl/fft_axil_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the FFT AXI4-Lite register file.
package fft_axil_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam int unsigned REG_CTRL = 0;
   localparam int unsigned REG_CFG  = 1;
   localparam int unsigned REG_LEN  = 2;
   localparam int unsigned REG_STAT = 3;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HOLD_AW,
      W_HOLD_W,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_e;

   // Replace each byte of old_val whose strobe bit is set with the matching byte of data.
   function automatic logic [DATA_W-1:0] apply_wstrb(input logic [DATA_W-1:0] old_val,
                                                     input logic [DATA_W-1:0] data,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int b = 0; b < int'(STRB_W); b++) begin
         if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/fft_axil_slave_regs.sv
// AXI4-Lite responder holding the FFT core control/status registers.
module fft_axil_slave_regs
   import fft_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned NUM_REGS           = 4
) (
   input  logic                                  S_AXI_ACLK,
   input  logic                                  S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_AWADDR,
   input  logic [2:0]                            S_AXI_AWPROT,
   input  logic                                  S_AXI_AWVALID,
   output logic                                  S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]       S_AXI_WSTRB,
   input  logic                                  S_AXI_WVALID,
   output logic                                  S_AXI_WREADY,
   output logic [1:0]                            S_AXI_BRESP,
   output logic                                  S_AXI_BVALID,
   input  logic                                  S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]         S_AXI_ARADDR,
   input  logic [2:0]                            S_AXI_ARPROT,
   input  logic                                  S_AXI_ARVALID,
   output logic                                  S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]         S_AXI_RDATA,
   output logic [1:0]                            S_AXI_RRESP,
   output logic                                  S_AXI_RVALID,
   input  logic                                  S_AXI_RREADY,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
   output logic [NUM_REGS-1:0]                   wr_pulse_o
);

   localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW    = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned IDX_W = C_S_AXI_ADDR_WIDTH - 2;

   wr_state_e        w_state, w_next;
   rd_state_e        r_state, r_next;

   logic [DW-1:0]    regs_q [NUM_REGS];
   logic [IDX_W-1:0] aw_idx_q;
   logic [DW-1:0]    wdata_q;
   logic [SW-1:0]    wstrb_q;
   logic             awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
   logic [DW-1:0]    rdata_q, rdata_n;
   logic [NUM_REGS-1:0] wr_pulse_q;

   logic             aw_hs, w_hs, ar_hs;
   logic             commit;
   logic [IDX_W-1:0] commit_idx;
   logic [DW-1:0]    commit_data;
   logic [SW-1:0]    commit_strb;
   logic             unused_ok;

   assign aw_hs = S_AXI_AWVALID && awready_q;
   assign w_hs  = S_AXI_WVALID  && wready_q;
   assign ar_hs = S_AXI_ARVALID && arready_q;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   // Write FSM next state; a commit fires on the edge that completes the AW/W pair.
   always_comb begin
      w_next      = w_state;
      commit      = 1'b0;
      commit_idx  = S_AXI_AWADDR[AW-1:2];
      commit_data = S_AXI_WDATA;
      commit_strb = S_AXI_WSTRB;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               w_next = W_RESP;
               commit = 1'b1;
            end else if (aw_hs) begin
               w_next = W_HOLD_AW;
            end else if (w_hs) begin
               w_next = W_HOLD_W;
            end
         end
         W_HOLD_AW: begin
            commit_idx = aw_idx_q;
            if (w_hs) begin
               w_next = W_RESP;
               commit = 1'b1;
            end
         end
         W_HOLD_W: begin
            commit_data = wdata_q;
            commit_strb = wstrb_q;
            if (aw_hs) begin
               w_next = W_RESP;
               commit = 1'b1;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Read FSM next state; read data is captured from the pre-commit register value.
   always_comb begin
      r_next  = r_state;
      rdata_n = rdata_q;
      case (r_state)
         R_IDLE: begin
            if (ar_hs) begin
               r_next  = R_RESP;
               rdata_n = regs_q[S_AXI_ARADDR[AW-1:2]];
            end
         end
         R_RESP: begin
            if (S_AXI_RREADY) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   // State, holding buffers, register file and registered handshake outputs.
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         w_state    <= W_IDLE;
         r_state    <= R_IDLE;
         aw_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         wr_pulse_q <= '0;
         for (int k = 0; k < int'(NUM_REGS); k++) regs_q[k] <= '0;
      end else begin
         w_state    <= w_next;
         r_state    <= r_next;
         awready_q  <= (w_next == W_IDLE) || (w_next == W_HOLD_W);
         wready_q   <= (w_next == W_IDLE) || (w_next == W_HOLD_AW);
         bvalid_q   <= (w_next == W_RESP);
         arready_q  <= (r_next == R_IDLE);
         rvalid_q   <= (r_next == R_RESP);
         rdata_q    <= rdata_n;
         wr_pulse_q <= commit ? (NUM_REGS'(1) << commit_idx) : '0;
         if (aw_hs) aw_idx_q <= S_AXI_AWADDR[AW-1:2];
         if (w_hs) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
         end
         if (commit) regs_q[commit_idx] <= apply_wstrb(regs_q[commit_idx], commit_data, commit_strb);
      end
   end

   // Flatten the register file onto the configuration bus.
   always_comb begin
      regs_o = '0;
      for (int k = 0; k < int'(NUM_REGS); k++) regs_o[k*DW +: DW] = regs_q[k];
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign wr_pulse_o    = wr_pulse_q;

endmodule

// File: tb/tb_fft_axil_slave_regs.sv
// Directed bench for the FFT AXI4-Lite register file.
module tb_fft_axil_slave_regs;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [127:0] regs;
   logic [3:0]  wr_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fft_axil_slave_regs dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(resetn),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .regs_o(regs), .wr_pulse_o(wr_pulse)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Simultaneous AW/W write, then B handshake; reports response and the pulse seen with BVALID.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [3:0] pulse, output bit ok);
      bit aw_done, w_done, aw_now, w_now;
      int n;
      aw_done = 0; w_done = 0; ok = 1; resp = 2'b11; pulse = '0;
      awaddr = addr; wdata = data; wstrb = strb; awvalid = 1; wvalid = 1;
      n = 0;
      while (!(aw_done && w_done) && n < 20) begin
         aw_now = awvalid && awready;
         w_now  = wvalid && wready;
         step();
         if (aw_now) begin aw_done = 1; awvalid = 0; end
         if (w_now)  begin w_done  = 1; wvalid  = 0; end
         n++;
      end
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) ok = 0;
      n = 0;
      while (!bvalid && n < 20) begin step(); n++; end
      if (!bvalid) ok = 0;
      resp = bresp; pulse = wr_pulse;
      bready = 1; step(); bready = 0;
   endtask

   // Single read with RREADY raised as soon as RVALID appears.
   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output bit ok);
      int n;
      ok = 1; araddr = addr; arvalid = 1;
      n = 0;
      while (!arready && n < 20) begin step(); n++; end
      if (!arready) ok = 0;
      step();
      arvalid = 0;
      if (!rvalid) ok = 0;
      data = rdata; resp = rresp;
      rready = 1; step(); rready = 0;
   endtask

   task automatic test_reset();
      resetn = 0;
      repeat (3) step();
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || wr_pulse !== 4'b0 || rdata !== 32'h0 || regs !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_state: rdy/valid=%b pulse=%b rdata=%h regs=%h, required all zero",
                  {awready, wready, arready, bvalid, rvalid}, wr_pulse, rdata, regs);
      end
      resetn = 1;
      step();
      n_checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_fail++;
         $display("FAIL ready_after_reset: aw/w/ar ready=%b, required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_simul_writes();
      logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; bit ok;
      for (int i = 0; i < 4; i++) begin
         axi_write(4'(i*4), 32'(i+1), 4'hF, resp, pulse, ok);
         n_checks++;
         if (!ok || resp !== 2'b00 || pulse !== 4'(1 << i)) begin
            n_fail++;
            $display("FAIL simul_write[%0d]: ok=%0d bresp=%b pulse=%b, required ok=1 bresp=00 pulse=%b",
                     i, ok, resp, pulse, 4'(1 << i));
         end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(i*4), d, resp, ok);
         n_checks++;
         if (!ok || d !== 32'(i+1) || resp !== 2'b00) begin
            n_fail++;
            $display("FAIL readback[%0d]: ok=%0d rdata=%h rresp=%b, required %h/00", i, ok, d, resp, 32'(i+1));
         end
      end
      n_checks++;
      if (regs !== 128'h00000004_00000003_00000002_00000001) begin
         n_fail++;
         $display("FAIL regs_flat: got %h, required 00000004000000030000000200000001", regs);
      end
   endtask

   task automatic test_aw_first();
      awaddr = 4'h4; awvalid = 1;
      step();
      awvalid = 0;
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (awready !== 1'b0 || bvalid !== 1'b0 || wr_pulse !== 4'b0 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_held[%0d]: awready=%b wready=%b bvalid=%b pulse=%b, required 0/1/0/0000",
                     c, awready, wready, bvalid, wr_pulse);
         end
         if (c < 2) step();
      end
      wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
      step();
      wvalid = 0;
      n_checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 4'b0010 || regs[63:32] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL aw_first_commit: bvalid=%b pulse=%b reg1=%h, required 1/0010/deadbeef",
                  bvalid, wr_pulse, regs[63:32]);
      end
      bready = 1; step(); bready = 0;
      n_checks++;
      if (bvalid !== 1'b0 || wr_pulse !== 4'b0) begin
         n_fail++;
         $display("FAIL aw_first_after_b: bvalid=%b pulse=%b, required 0/0000", bvalid, wr_pulse);
      end
   endtask

   task automatic test_w_first();
      wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1;
      step();
      wvalid = 0;
      step();
      n_checks++;
      if (wready !== 1'b0 || awready !== 1'b1 || bvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL w_held: wready=%b awready=%b bvalid=%b, required 0/1/0", wready, awready, bvalid);
      end
      awaddr = 4'h8; awvalid = 1;
      step();
      awvalid = 0;
      n_checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 4'b0100 || regs[95:64] !== 32'h00000055) begin
         n_fail++;
         $display("FAIL w_first_commit: bvalid=%b pulse=%b reg2=%h, required 1/0100/00000055",
                  bvalid, wr_pulse, regs[95:64]);
      end
      bready = 1; step(); bready = 0;
   endtask

   task automatic test_wstrb();
      logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; bit ok;
      axi_write(4'h8, 32'h11223344, 4'hF, resp, pulse, ok);
      axi_write(4'h8, 32'hAABBCCDD, 4'b0101, resp, pulse, ok);
      axi_read(4'h8, d, resp, ok);
      n_checks++;
      if (!ok || d !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL wstrb_merge: ok=%0d rdata=%h, required 11bb33dd", ok, d);
      end
      axi_write(4'hA, 32'hFFFFFFFF, 4'b0000, resp, pulse, ok);
      n_checks++;
      if (!ok || resp !== 2'b00 || pulse !== 4'b0100 || regs[95:64] !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL wstrb_zero: ok=%0d bresp=%b pulse=%b reg2=%h, required 1/00/0100/11bb33dd",
                  ok, resp, pulse, regs[95:64]);
      end
   endtask

   task automatic test_bready_stall();
      awaddr = 4'hC; wdata = 32'hCAFE0003; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      step();
      wdata = 32'h00000077;
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || regs[127:96] !== 32'hCAFE0003) begin
            n_fail++;
            $display("FAIL bready_stall[%0d]: bvalid=%b awready=%b wready=%b reg3=%h, required 1/0/0/cafe0003",
                     c, bvalid, awready, wready, regs[127:96]);
         end
         step();
      end
      bready = 1; step(); bready = 0;
      n_checks++;
      if (bvalid !== 1'b0 || awready !== 1'b1 || regs[127:96] !== 32'hCAFE0003) begin
         n_fail++;
         $display("FAIL stall_release: bvalid=%b awready=%b reg3=%h, required 0/1/cafe0003",
                  bvalid, awready, regs[127:96]);
      end
      step();
      awvalid = 0; wvalid = 0;
      n_checks++;
      if (bvalid !== 1'b1 || regs[127:96] !== 32'h00000077 || wr_pulse !== 4'b1000) begin
         n_fail++;
         $display("FAIL second_write: bvalid=%b reg3=%h pulse=%b, required 1/00000077/1000",
                  bvalid, regs[127:96], wr_pulse);
      end
      bready = 1; step(); bready = 0;
   endtask

   task automatic test_read_old();
      logic [1:0] resp; logic [3:0] pulse; logic [31:0] d; bit ok;
      araddr = 4'h4; arvalid = 1;
      step();
      arvalid = 0;
      axi_write(4'h4, 32'h12345678, 4'hF, resp, pulse, ok);
      step();
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || arready !== 1'b0 || regs[63:32] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL r_stall_hold: rvalid=%b rdata=%h arready=%b reg1=%h, required 1/deadbeef/0/12345678",
                  rvalid, rdata, arready, regs[63:32]);
      end
      rready = 1; step(); rready = 0;
      n_checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         n_fail++;
         $display("FAIL r_release: rvalid=%b arready=%b, required 0/1", rvalid, arready);
      end
      axi_read(4'h4, d, resp, ok);
      n_checks++;
      if (!ok || d !== 32'h12345678) begin
         n_fail++;
         $display("FAIL read_new: ok=%0d rdata=%h, required 12345678", ok, d);
      end
      araddr = 4'h0; arvalid = 1;
      awaddr = 4'h0; wdata = 32'hA0A0A0A0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      step();
      arvalid = 0; awvalid = 0; wvalid = 0;
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h00000001 || regs[31:0] !== 32'hA0A0A0A0) begin
         n_fail++;
         $display("FAIL same_edge_read_old: rvalid=%b rdata=%h reg0=%h, required 1/00000001/a0a0a0a0",
                  rvalid, rdata, regs[31:0]);
      end
      rready = 1; bready = 1; step(); rready = 0; bready = 0;
   endtask

   task automatic test_back_to_back();
      bready = 1;
      awaddr = 4'h0; wdata = 32'h0000B2B0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      step();
      n_checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 4'b0001 || awready !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_first: bvalid=%b pulse=%b awready=%b, required 1/0001/0", bvalid, wr_pulse, awready);
      end
      awaddr = 4'h4; wdata = 32'h0000B2B1;
      step();
      n_checks++;
      if (bvalid !== 1'b0 || wr_pulse !== 4'b0000 || awready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_gap: bvalid=%b pulse=%b awready=%b, required 0/0000/1", bvalid, wr_pulse, awready);
      end
      step();
      awvalid = 0; wvalid = 0;
      n_checks++;
      if (bvalid !== 1'b1 || wr_pulse !== 4'b0010 || regs[63:0] !== 64'h0000B2B1_0000B2B0) begin
         n_fail++;
         $display("FAIL b2b_second: bvalid=%b pulse=%b regs10=%h, required 1/0010/0000b2b10000b2b0",
                  bvalid, wr_pulse, regs[63:0]);
      end
      step();
      bready = 0;
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [3:0] pulse; bit ok;
      awaddr = 4'h0; awvalid = 1;
      araddr = 4'h8; arvalid = 1;
      step();
      awvalid = 0; arvalid = 0;
      resetn = 0;
      step();
      n_checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || regs !== 128'h0 || wr_pulse !== 4'b0 || rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: rdy/valid=%b regs=%h pulse=%b rdata=%h, required all zero",
                  {awready, wready, arready, bvalid, rvalid}, regs, wr_pulse, rdata);
      end
      resetn = 1;
      step();
      wdata = 32'h0000C0DE; wstrb = 4'hF; wvalid = 1;
      step();
      wvalid = 0;
      step();
      n_checks++;
      if (bvalid !== 1'b0 || wr_pulse !== 4'b0 || regs !== 128'h0) begin
         n_fail++;
         $display("FAIL aw_discarded: bvalid=%b pulse=%b regs=%h, required 0/0000/0", bvalid, wr_pulse, regs);
      end
      awaddr = 4'hC; awvalid = 1;
      step();
      awvalid = 0;
      n_checks++;
      if (bvalid !== 1'b1 || regs[127:96] !== 32'h0000C0DE || regs[95:0] !== 96'h0) begin
         n_fail++;
         $display("FAIL post_reset_write: bvalid=%b regs=%h, required 1 with reg3=0000c0de only", bvalid, regs);
      end
      bready = 1; step(); bready = 0;
      axi_write(4'h4, 32'h1, 4'hF, resp, pulse, ok);
      n_checks++;
      if (!ok || pulse !== 4'b0010) begin
         n_fail++;
         $display("FAIL post_reset_normal: ok=%0d pulse=%b, required 1/0010", ok, pulse);
      end
   endtask

   initial begin
      resetn = 0; awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b101;
      awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      wdata = '0; wstrb = '0;
      test_reset();
      test_simul_writes();
      test_aw_first();
      test_w_first();
      test_wstrb();
      test_bready_stall();
      test_read_old();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
